// File: rtl/ram_io_responder_if.sv
// rtl/ram_io_responder_if.sv - bus bundle between the memory controller/UART environment and ram_io_responder
// Signals:
//   rdy, mem_a, mem_write, is_write      - per-cycle memory access from the controller
//   mem_result, cannot_read              - read data (1-cycle latency) and TX backpressure
//   tx_data, tx_valid, tx_ready          - TX byte stream out of the responder
//   rx_data, rx_valid, rx_ready          - RX byte stream into the responder
//   halted, tx_overflow                  - sticky status flags
// Modports: master = controller/environment side, slave = responder side.
interface ram_io_responder_if;
  logic        rdy;
  logic [31:0] mem_a;
  logic [7:0]  mem_write;
  logic        is_write;
  logic [7:0]  mem_result;
  logic        cannot_read;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        halted;
  logic        tx_overflow;

  modport master (
    output rdy, mem_a, mem_write, is_write, tx_ready, rx_data, rx_valid,
    input  mem_result, cannot_read, tx_data, tx_valid, rx_ready, halted, tx_overflow
  );

  modport slave (
    input  rdy, mem_a, mem_write, is_write, tx_ready, rx_data, rx_valid,
    output mem_result, cannot_read, tx_data, tx_valid, rx_ready, halted, tx_overflow
  );
endinterface

// File: rtl/ram_io_responder.sv
// rtl/ram_io_responder.sv - byte RAM plus memory-mapped UART FIFOs behind the byte-serial memory bus
// Ports:
//   clk - single clock
//   rst - synchronous active-high reset (FIFOs, flags and mem_result; RAM contents kept)
//   bus - slave side of ram_io_responder_if
// Address map: mem_a[17:16]==2'b11 selects IO (0x30000 data, 0x30004 status/halt),
// everything else is RAM indexed by mem_a[ADDR_WIDTH-1:0].
module ram_io_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int TX_DEPTH   = 8,
  parameter int RX_DEPTH   = 8
) (
  input logic               clk,
  input logic               rst,
  ram_io_responder_if.slave bus
);
  localparam int TXW = $clog2(TX_DEPTH);
  localparam int RXW = $clog2(RX_DEPTH);
  localparam logic [TXW:0] TX_FULL_CNT = (TXW+1)'(TX_DEPTH);
  localparam logic [TXW:0] TX_HI_CNT   = (TXW+1)'(TX_DEPTH - 1);
  localparam logic [RXW:0] RX_FULL_CNT = (RXW+1)'(RX_DEPTH);

  logic [7:0]           ram [2**ADDR_WIDTH];
  logic [7:0]           tx_mem [TX_DEPTH];
  logic [7:0]           rx_mem [RX_DEPTH];
  logic [TXW-1:0]       tx_rd_ptr, tx_wr_ptr;
  logic [TXW:0]         tx_count;
  logic [RXW-1:0]       rx_rd_ptr, rx_wr_ptr;
  logic [RXW:0]         rx_count;
  logic [7:0]           mem_result_q, result_next;
  logic                 halted_q, tx_overflow_q;

  logic                 access, is_io, io_data, io_status;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                 tx_full, tx_nonempty, tx_pop, tx_push_req, tx_push;
  logic                 rx_full, rx_nonempty, rx_ready_i, rx_push, rx_pop;
  logic                 unused_addr_bits;

  // An access presented while rst is high must have no effect.
  assign access    = bus.rdy && !rst;
  assign is_io     = (bus.mem_a[17:16] == 2'b11);
  assign io_data   = is_io && (bus.mem_a[15:0] == 16'h0000);
  assign io_status = is_io && (bus.mem_a[15:0] == 16'h0004);
  assign ram_addr  = bus.mem_a[ADDR_WIDTH-1:0];
  assign unused_addr_bits = ^bus.mem_a[31:18];

  assign tx_full     = (tx_count == TX_FULL_CNT);
  assign tx_nonempty = (tx_count != '0);
  assign tx_pop      = tx_nonempty && bus.tx_ready;
  assign tx_push_req = access && io_data && bus.is_write;
  // A full FIFO still takes the byte when the head leaves in the same cycle.
  assign tx_push     = tx_push_req && (!tx_full || tx_pop);

  assign rx_full     = (rx_count == RX_FULL_CNT);
  assign rx_nonempty = (rx_count != '0);
  assign rx_ready_i  = !rx_full && !rst;
  assign rx_push     = bus.rx_valid && rx_ready_i;
  assign rx_pop      = access && io_data && !bus.is_write && rx_nonempty;

  always_comb begin
    result_next = mem_result_q;
    if (access) begin
      if (bus.is_write)  result_next = 8'h00;
      else if (!is_io)   result_next = ram[ram_addr];
      else if (io_data)  result_next = rx_nonempty ? rx_mem[rx_rd_ptr] : 8'h00;
      else if (io_status) result_next = {6'b0, rx_nonempty, tx_full};
      else               result_next = 8'h00;
    end
  end

  // Storage arrays carry no reset; their enables already exclude the rst cycle.
  always_ff @(posedge clk) begin
    if (access && bus.is_write && !is_io) ram[ram_addr] <= bus.mem_write;
    if (tx_push) tx_mem[tx_wr_ptr] <= bus.mem_write;
    if (rx_push) rx_mem[rx_wr_ptr] <= bus.rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_result_q  <= 8'h00;
      tx_rd_ptr     <= '0;
      tx_wr_ptr     <= '0;
      tx_count      <= '0;
      rx_rd_ptr     <= '0;
      rx_wr_ptr     <= '0;
      rx_count      <= '0;
      halted_q      <= 1'b0;
      tx_overflow_q <= 1'b0;
    end else begin
      mem_result_q <= result_next;
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + TXW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TXW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + (TXW+1)'(1);
        2'b01:   tx_count <= tx_count - (TXW+1)'(1);
        default: tx_count <= tx_count;
      endcase
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + RXW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RXW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + (RXW+1)'(1);
        2'b01:   rx_count <= rx_count - (RXW+1)'(1);
        default: rx_count <= rx_count;
      endcase
      if (access && io_status && bus.is_write) halted_q <= 1'b1;
      if (tx_push_req && !tx_push)             tx_overflow_q <= 1'b1;
    end
  end

  assign bus.mem_result  = mem_result_q;
  // From the registered count only, so one slot stays free for a write already in flight.
  assign bus.cannot_read = (tx_count >= TX_HI_CNT);
  assign bus.tx_data     = tx_mem[tx_rd_ptr];
  assign bus.tx_valid    = tx_nonempty;
  assign bus.rx_ready    = rx_ready_i;
  assign bus.halted      = halted_q;
  assign bus.tx_overflow = tx_overflow_q;
endmodule

// File: tb/tb_ram_io_responder.sv
// tb/tb_ram_io_responder.sv - self-checking bench for ram_io_responder
module tb_ram_io_responder;
  localparam int TX_DEPTH = 8;
  localparam int RX_DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_io_responder_if bus();

  ram_io_responder #(.ADDR_WIDTH(17), .TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks;
  int n_err;

  // Reference model: byte memory, two byte queues, sticky flags.
  logic [7:0] m_ram [int];
  logic [7:0] m_tx [$];
  logic [7:0] m_rx [$];
  logic [7:0] m_result;
  bit         m_known;
  bit         m_halted;
  bit         m_ovf;

  typedef struct {
    bit          rdy;
    bit          we;
    logic [31:0] a;
    logic [7:0]  wd;
    logic [7:0]  exp;
  } vec_t;
  vec_t vecs [$];

  function automatic vec_t mk(bit r, bit w, logic [31:0] a, logic [7:0] d, logic [7:0] e);
    vec_t v;
    v.rdy = r; v.we = w; v.a = a; v.wd = d; v.exp = e;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    int tx_n = m_tx.size();
    int rx_n = m_rx.size();
    bit tx_pop;
    bit rx_can;
    bit io;
    int off;
    int idx;
    if (rst) begin
      m_tx.delete(); m_rx.delete();
      m_result = 8'h00; m_known = 1; m_halted = 0; m_ovf = 0;
      return;
    end
    tx_pop = (tx_n > 0) && bus.tx_ready;
    rx_can = (rx_n < RX_DEPTH);
    if (tx_pop) void'(m_tx.pop_front());
    if (bus.rdy) begin
      io  = (bus.mem_a[17:16] == 2'b11);
      off = int'(bus.mem_a[15:0]);
      idx = int'(bus.mem_a[16:0]);
      m_known = 1;
      if (bus.is_write) begin
        m_result = 8'h00;
        if (!io) m_ram[idx] = bus.mem_write;
        else if (off == 0) begin
          if (tx_n < TX_DEPTH || tx_pop) m_tx.push_back(bus.mem_write);
          else m_ovf = 1;
        end else if (off == 4) m_halted = 1;
      end else begin
        if (!io) begin
          if (m_ram.exists(idx)) m_result = m_ram[idx];
          else m_known = 0;
        end else if (off == 0) m_result = (rx_n > 0) ? m_rx.pop_front() : 8'h00;
        else if (off == 4) m_result = {6'b0, rx_n > 0, tx_n == TX_DEPTH};
        else m_result = 8'h00;
      end
    end
    if (bus.rx_valid && rx_can) m_rx.push_back(bus.rx_data);
  endtask

  task automatic check_model();
    if (m_known) chk("model mem_result", 32'(bus.mem_result), 32'(m_result));
    chk("model tx_valid", 32'(bus.tx_valid), 32'(m_tx.size() != 0));
    if (m_tx.size() != 0) chk("model tx_data", 32'(bus.tx_data), 32'(m_tx[0]));
    chk("model cannot_read", 32'(bus.cannot_read), 32'(m_tx.size() >= TX_DEPTH - 1));
    chk("model rx_ready", 32'(bus.rx_ready), 32'(!rst && (m_rx.size() < RX_DEPTH)));
    chk("model halted", 32'(bus.halted), 32'(m_halted));
    chk("model tx_overflow", 32'(bus.tx_overflow), 32'(m_ovf));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic bus_op(bit r, bit w, logic [31:0] a, logic [7:0] d);
    bus.rdy = r; bus.is_write = w; bus.mem_a = a; bus.mem_write = d;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_op(0, 0, 32'h0, 8'h00);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_checks = 0; n_err = 0;
    m_result = 8'h00; m_known = 1; m_halted = 0; m_ovf = 0;
    rst = 1'b1;
    bus.rdy = 0; bus.mem_a = 32'h0; bus.mem_write = 8'h00; bus.is_write = 0;
    bus.tx_ready = 0; bus.rx_data = 8'h00; bus.rx_valid = 0;
    tick(); tick();
    chk("reset mem_result", 32'(bus.mem_result), 32'h00);
    chk("reset tx_valid", 32'(bus.tx_valid), 32'h0);
    chk("reset cannot_read", 32'(bus.cannot_read), 32'h0);
    chk("reset halted", 32'(bus.halted), 32'h0);
    chk("reset tx_overflow", 32'(bus.tx_overflow), 32'h0);
    chk("reset rx_ready during rst", 32'(bus.rx_ready), 32'h0);
    rst = 1'b0;
    bus_op(0, 0, 32'h0, 8'h00);
    chk("rx_ready after rst", 32'(bus.rx_ready), 32'h1);

    // RAM word, rdy gating, IO reads on empty FIFOs, RAM top boundary.
    vecs.push_back(mk(1, 1, 32'h100,   8'h78, 8'h00));
    vecs.push_back(mk(1, 1, 32'h101,   8'h56, 8'h00));
    vecs.push_back(mk(1, 1, 32'h102,   8'h34, 8'h00));
    vecs.push_back(mk(1, 1, 32'h103,   8'h12, 8'h00));
    vecs.push_back(mk(1, 0, 32'h100,   8'h00, 8'h78));
    vecs.push_back(mk(1, 0, 32'h101,   8'h00, 8'h56));
    vecs.push_back(mk(1, 0, 32'h102,   8'h00, 8'h34));
    vecs.push_back(mk(1, 0, 32'h103,   8'h00, 8'h12));
    vecs.push_back(mk(1, 1, 32'h200,   8'h55, 8'h00));
    vecs.push_back(mk(1, 0, 32'h200,   8'h00, 8'h55));
    vecs.push_back(mk(0, 1, 32'h200,   8'hAA, 8'h55));
    vecs.push_back(mk(0, 0, 32'h103,   8'h00, 8'h55));
    vecs.push_back(mk(1, 0, 32'h200,   8'h00, 8'h55));
    vecs.push_back(mk(1, 0, 32'h30008, 8'h00, 8'h00));
    vecs.push_back(mk(1, 0, 32'h30004, 8'h00, 8'h00));
    vecs.push_back(mk(1, 0, 32'h30000, 8'h00, 8'h00));
    vecs.push_back(mk(1, 1, 32'h100,   8'h9A, 8'h00));
    vecs.push_back(mk(1, 0, 32'h100,   8'h00, 8'h9A));
    vecs.push_back(mk(1, 1, 32'h1FFFF, 8'hC3, 8'h00));
    vecs.push_back(mk(1, 0, 32'h1FFFF, 8'h00, 8'hC3));
    for (int i = 0; i < vecs.size(); i++) begin
      bus_op(vecs[i].rdy, vecs[i].we, vecs[i].a, vecs[i].wd);
      chk($sformatf("vec%0d mem_result", i), 32'(bus.mem_result), 32'(vecs[i].exp));
    end

    // RX path.
    bus.rx_valid = 1; bus.rx_data = 8'h11;
    bus_op(0, 0, 32'h0, 8'h00);
    bus.rx_data = 8'h22;
    bus_op(0, 0, 32'h0, 8'h00);
    bus.rx_valid = 0;
    bus_op(1, 0, 32'h30004, 8'h00);
    chk("rx status", 32'(bus.mem_result), 32'h02);
    bus_op(1, 0, 32'h30000, 8'h00);
    chk("rx read 1", 32'(bus.mem_result), 32'h11);
    bus_op(1, 0, 32'h30000, 8'h00);
    chk("rx read 2", 32'(bus.mem_result), 32'h22);
    bus_op(1, 0, 32'h30000, 8'h00);
    chk("rx read empty", 32'(bus.mem_result), 32'h00);

    // TX backpressure, overflow and drain.
    do_reset();
    bus.tx_ready = 0;
    for (int i = 1; i <= 7; i++) begin
      bus_op(1, 1, 32'h30000, 8'h41);
      chk($sformatf("bp cannot_read after write %0d", i), 32'(bus.cannot_read), 32'(i >= 7));
    end
    bus_op(1, 1, 32'h30000, 8'h41);
    chk("bp 8th write no overflow", 32'(bus.tx_overflow), 32'h0);
    bus_op(1, 1, 32'h30000, 8'h41);
    chk("bp 9th write overflow", 32'(bus.tx_overflow), 32'h1);
    bus_op(1, 0, 32'h30004, 8'h00);
    chk("bp status full", 32'(bus.mem_result), 32'h01);
    bus.tx_ready = 1;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("drain byte %0d", k), 32'(bus.tx_data), 32'h41);
      bus_op(0, 0, 32'h0, 8'h00);
      chk($sformatf("drain cannot_read %0d", k), 32'(bus.cannot_read), 32'((8 - k) >= 7));
      chk($sformatf("drain tx_valid %0d", k), 32'(bus.tx_valid), 32'(k < 8));
    end
    bus.tx_ready = 0;

    // Push into a full TX FIFO while its head drains.
    do_reset();
    for (int i = 0; i < 8; i++) bus_op(1, 1, 32'h30000, 8'(8'h50 + i));
    chk("sim full cannot_read", 32'(bus.cannot_read), 32'h1);
    bus.tx_ready = 1;
    bus_op(1, 1, 32'h30000, 8'h99);
    bus.tx_ready = 0;
    chk("sim no overflow", 32'(bus.tx_overflow), 32'h0);
    chk("sim head after pop", 32'(bus.tx_data), 32'h51);
    bus_op(1, 0, 32'h30004, 8'h00);
    chk("sim still full", 32'(bus.mem_result), 32'h01);

    // Reset in the middle of traffic.
    do_reset();
    for (int i = 0; i < 3; i++) bus_op(1, 1, 32'h30000, 8'(8'h60 + i));
    bus_op(1, 1, 32'h30004, 8'h00);
    chk("mid halted set", 32'(bus.halted), 32'h1);
    bus_op(1, 0, 32'h100, 8'h00);
    chk("mid ram read", 32'(bus.mem_result), 32'h9A);
    rst = 1'b1;
    bus_op(1, 1, 32'h30004, 8'h00);
    chk("mid rst tx_valid", 32'(bus.tx_valid), 32'h0);
    chk("mid rst cannot_read", 32'(bus.cannot_read), 32'h0);
    chk("mid rst mem_result", 32'(bus.mem_result), 32'h00);
    chk("mid rst halted", 32'(bus.halted), 32'h0);
    rst = 1'b0;
    bus_op(0, 0, 32'h0, 8'h00);
    chk("mid write in rst ignored", 32'(bus.halted), 32'h0);
    bus_op(1, 1, 32'h30004, 8'h00);
    chk("mid halt after rst", 32'(bus.halted), 32'h1);

    // Randomized traffic against the model.
    for (int i = 0; i < 16; i++) bus_op(1, 1, 32'(i), 8'($urandom));
    for (int n = 0; n < 2000; n++) begin
      rst           = ($urandom_range(0, 99) == 0);
      bus.rdy       = ($urandom_range(0, 9) != 0);
      bus.is_write  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 6))
        0, 1, 2: bus.mem_a = 32'($urandom_range(0, 15));
        3, 4:    bus.mem_a = 32'h30000;
        5:       bus.mem_a = 32'h30004;
        default: bus.mem_a = 32'h3000C;
      endcase
      bus.mem_write = 8'($urandom);
      bus.tx_ready  = ($urandom_range(0, 3) == 0);
      bus.rx_valid  = 1'($urandom_range(0, 1));
      bus.rx_data   = 8'($urandom);
      tick();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
